nx1_wb_initiator: RTL and testbench

Single-outstanding Wishbone classic-cycle initiator that drives the Neuromorphic X1 Wishbone slave port from a simple valid/ready command stream. It sits between a local controller (scan/test sequencer or host bridge) and the X1 macro wrapper. It converts each command into one Wishbone read or write cycle and returns a response with read data or a timeout error. A bus-hang timeout ensures a missing `wbs_ack_o` from the macro can never lock up the controller.

---
 rtl/nx1_wb_initiator_if.sv | 43 ++++
 rtl/nx1_wb_initiator.sv | 141 ++++++++++++++
 tb/tb_nx1_wb_initiator.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/nx1_wb_initiator_if.sv
// Command, response and Wishbone master signal bundle for nx1_wb_initiator.
// The master modport is the initiator's view; the slave modport is the view of
// whatever surrounds it (controller on the command side, X1 macro on the bus side).
interface nx1_wb_initiator_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/nx1_wb_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator for the Neuromorphic X1
// slave port. Each accepted command becomes one read or write cycle; a missing
// ack is converted into an error response after TIMEOUT_CYCLES+1 bus cycles.
module nx1_wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  nx1_wb_initiator_if.master   bus,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     txn_cnt_o,
  output logic [CNT_W-1:0]     tmo_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_run;
  logic               r_cyc;
  logic               r_we;
  logic [3:0]         r_sel;
  logic [31:0]        r_adr;
  logic [31:0]        r_dat;
  logic               r_rsp_vld;
  logic               r_rsp_err;
  logic [31:0]        r_rsp_dat;
  logic [CNT_W-1:0]   r_tmo_ctr;
  logic [CNT_W-1:0]   r_txn_cnt;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic               w_cmd_ready;
  logic               w_accept;
  logic               w_ack;
  logic               w_timeout;

  // Ack only counts while a cycle is in flight; ack beats timeout in the same cycle.
  assign w_accept  = bus.cmd_valid_i & w_cmd_ready;
  assign w_ack     = (r_state == S_BUS) & bus.wbm_ack_i;
  assign w_timeout = (r_state == S_BUS) & ~bus.wbm_ack_i & (TIMEOUT_CYCLES != 0) &
                     (r_tmo_ctr == CNT_W'(TIMEOUT_CYCLES));

  // Goes high on the first edge after reset release so cmd_ready stays low during reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_run <= 1'b0;
    else            r_run <= 1'b1;
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)            w_state_nxt = S_BUS;
      S_BUS:   if (w_ack || w_timeout)  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready_i)     w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_cmd_ready = r_run & (r_state == S_IDLE);
    busy_o      = (r_state != S_IDLE);
  end

  // Wishbone request registers: loaded on accept, held through BUS/RESP/IDLE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_accept) begin
      r_cyc <= 1'b1;
      r_we  <= bus.cmd_we_i;
      r_sel <= bus.cmd_sel_i;
      r_adr <= bus.cmd_adr_i;
      r_dat <= bus.cmd_dat_i;
    end else if (w_ack || w_timeout) begin
      r_cyc <= 1'b0;
    end
  end

  // Bus-hang timer: cleared on accept, counts BUS cycles without ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                                    r_tmo_ctr <= '0;
    else if (w_accept)                                 r_tmo_ctr <= '0;
    else if (r_state == S_BUS && !bus.wbm_ack_i)       r_tmo_ctr <= r_tmo_ctr + 1'b1;
  end

  // Response registers: captured at bus completion, held until consumed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rsp_vld <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_dat <= '0;
    end else if (w_ack) begin
      r_rsp_vld <= 1'b1;
      r_rsp_err <= 1'b0;
      r_rsp_dat <= r_we ? 32'h0 : bus.wbm_dat_i;
    end else if (w_timeout) begin
      r_rsp_vld <= 1'b1;
      r_rsp_err <= 1'b1;
      r_rsp_dat <= 32'h0;
    end else if (r_state == S_RESP && bus.rsp_ready_i) begin
      r_rsp_vld <= 1'b0;
    end
  end

  // Completion and timeout statistics; both wrap freely.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_txn_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_ack || w_timeout) r_txn_cnt <= r_txn_cnt + 1'b1;
      if (w_timeout)          r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign bus.cmd_ready_o = w_cmd_ready;
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = r_cyc;
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_sel_o   = r_sel;
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_dat;
  assign bus.rsp_valid_o = r_rsp_vld;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_dat_o   = r_rsp_dat;
  assign txn_cnt_o       = r_txn_cnt;
  assign tmo_cnt_o       = r_tmo_cnt;

endmodule

// File: tb/tb_nx1_wb_initiator.sv
// Self-checking bench for nx1_wb_initiator: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_nx1_wb_initiator;
  localparam int T     = 8;
  localparam int CNT_W = 4;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [CNT_W-1:0] txn, tmo;

  int n_checks = 0;
  int n_errors = 0;
  int m_txn = 0;
  int m_tmo = 0;
  time t_acc = 0;
  time t_prev = 0;

  nx1_wb_initiator_if bus();

  nx1_wb_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .busy_o    (busy),
    .txn_cnt_o (txn),
    .tmo_cnt_o (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction. Must be called positioned at a negedge; returns at a negedge.
  // dly = number of BUS cycles without ack before the slave acks (dly > T means never).
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly, input logic [31:0] rdat,
                        input int hold, input bit late_ack, input bit queue_next);
    int w, cyc_n, e_cyc;
    logic e_err;
    logic [31:0] e_dat;
    w = 0;
    while (!bus.cmd_ready_o && w < 50) begin @(negedge clk); w++; end
    chk("cmd_ready_idle", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    @(posedge clk);
    t_prev = t_acc;
    t_acc  = $time;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("cyc_stb_on", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd3);
    chk("wb_adr", bus.wbm_adr_o, adr);
    chk("wb_dat", bus.wbm_dat_o, dat);
    chk("wb_sel_we", {27'd0, bus.wbm_we_o, bus.wbm_sel_o}, {27'd0, we, sel});
    chk("busy_bus", {31'd0, busy}, 1);

    cyc_n = 0;
    while (bus.wbm_cyc_o && cyc_n < 64) begin
      bus.wbm_ack_i = (cyc_n == dly);
      bus.wbm_dat_i = (cyc_n == dly) ? rdat : $urandom;
      cyc_n++;
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;

    if (dly <= T) begin
      e_cyc = dly + 1; e_err = 1'b0; e_dat = we ? 32'h0 : rdat;
    end else begin
      e_cyc = T + 1;   e_err = 1'b1; e_dat = 32'h0;
    end
    m_txn = (m_txn + 1) & MASK;
    if (e_err) m_tmo = (m_tmo + 1) & MASK;

    chk("cyc_cycles", cyc_n, e_cyc);
    chk("stb_off", {31'd0, bus.wbm_stb_o}, 0);
    chk("rsp_valid", {31'd0, bus.rsp_valid_o}, 1);
    chk("rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, e_err});
    chk("rsp_dat", bus.rsp_dat_o, e_dat);
    chk("txn_cnt", {28'd0, txn}, m_txn);
    chk("tmo_cnt", {28'd0, tmo}, m_tmo);
    chk("cmd_ready_resp", {31'd0, bus.cmd_ready_o}, 0);

    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready_i = 1'b0;
      bus.wbm_ack_i   = late_ack && (i == 1);
      bus.wbm_dat_i   = 32'hDEAD_BEEF;
      if (queue_next) begin
        bus.cmd_valid_i = 1'b1;
        bus.cmd_adr_i   = ~adr;
      end
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.rsp_valid_o}, 1);
      chk("hold_dat_err", bus.rsp_dat_o ^ {31'd0, bus.rsp_err_o}, e_dat ^ {31'd0, e_err});
      chk("hold_no_cyc", {30'd0, bus.wbm_cyc_o, bus.cmd_ready_o}, 0);
      chk("hold_txn", {28'd0, txn}, m_txn);
    end
    bus.wbm_ack_i   = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    chk("rsp_dropped", {31'd0, bus.rsp_valid_o}, 0);
    chk("no_accept_on_release", {31'd0, bus.wbm_cyc_o}, 0);
    chk("idle_ready_busy", {30'd0, bus.cmd_ready_o, busy}, 32'd2);
    chk("adr_retained", bus.wbm_adr_o, adr);
  endtask

  initial begin
    logic we;
    logic [31:0] a;
    int d, h;
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_dat_i   = '0;
    bus.wbm_ack_i   = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.cmd_ready_o}, 0);
    chk("rst_cyc_rsp", {29'd0, bus.wbm_cyc_o, bus.rsp_valid_o, busy}, 0);
    chk("rst_cnts", {24'd0, txn, tmo}, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, bus.cmd_ready_o}, 1);

    // Write then read, slave acks after 3 wait cycles.
    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 3, 32'h1111_2222, 0, 1'b0, 1'b0);
    chk("write_txn_is_1", {28'd0, txn}, 1);
    do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'hCAFE_0001, 0, 1'b0, 1'b0);
    chk("read_txn_is_2", {28'd0, txn}, 2);

    // No ack: timeout, late ack during response hold is ignored.
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, 1000, 32'h5555_5555, 3, 1'b1, 1'b0);
    chk("tmo_is_1", {28'd0, tmo}, 1);

    // Ack on the exact timeout cycle wins.
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, T, 32'h1234_ABCD, 0, 1'b0, 1'b0);

    // Response backpressure with a queued command.
    do_txn(1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'h1, 1, 32'h0, 10, 1'b0, 1'b1);

    // Back-to-back with immediate ack and immediate consume: 3-cycle period.
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, 32'h3000_0100 + i * 4, 32'h0, 4'hF, 0, $urandom, 0, 1'b0, 1'b0);
      if (i > 0) chk("b2b_period", 32'(t_acc - t_prev), 32'd30);
    end

    // Reset during the second BUS cycle of a read.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h3000_0200;
    bus.cmd_sel_i   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("pre_rst_cyc", {31'd0, bus.wbm_cyc_o}, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_cyc_stb", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("midrst_rsp_busy", {30'd0, bus.rsp_valid_o, busy}, 0);
    chk("midrst_cnts", {24'd0, txn, tmo}, 0);
    chk("midrst_adr", bus.wbm_adr_o, 0);
    m_txn = 0;
    m_tmo = 0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.cmd_ready_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.cmd_ready_o}, 1);

    // 17 acked transactions wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++)
      do_txn(i[0], $urandom, $urandom, 4'(i), i % 4, $urandom, 0, 1'b0, 1'b0);
    chk("txn_wrap", {28'd0, txn}, 1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom_range(0, T + 2);
      h  = $urandom_range(0, 3);
      do_txn(we, a, $urandom, 4'($urandom), d, $urandom, h,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
